// File: rtl/request_mux_pkg.sv
// Shared types and helpers for the request arbiter/mux slice.
package request_mux_pkg;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed-priority or round-robin scan, with an
// optional lock override that grants only the locked channel.
module rr_arbiter
  import request_mux_pkg::*;
#(
  parameter int        N    = 16,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             lock_en,
  input  logic [SEL_W-1:0] lock_idx,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any_grant
);

  // Scan from the priority origin (0 or ptr) and grant the first requester.
  always_comb begin
    // NOTE: all outputs get a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    if (lock_en) begin
      // A locked packet owns the port; everyone else stalls, even if idle.
      if (req[lock_idx]) begin
        grant[lock_idx] = 1'b1;
        idx             = lock_idx;
        any_grant       = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (MODE == ARB_RR) ? (int'(ptr) + k) % N : k;
        if (!any_grant && req[j]) begin
          grant[j]  = 1'b1;
          idx       = SEL_W'(j);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/request_arbiter_mux.sv
// Arbitrates REQ_NUMBER valid/ready request channels onto one registered
// output beat with full backpressure and optional packet locking.
module request_arbiter_mux
  import request_mux_pkg::*;
#(
  parameter int        REQ_WIDTH    = 10,
  parameter int        REQ_NUMBER   = 16,
  parameter arb_mode_e ARB_MODE     = ARB_RR,
  parameter bit        LOCK_PACKETS = 1'b0,
  localparam int       SEL_W        = sel_width(REQ_NUMBER)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REQ_NUMBER-1:0] req_valid,
  input  logic [REQ_NUMBER-1:0] req_last,
  input  logic [REQ_WIDTH-1:0]  requests [REQ_NUMBER],
  output logic [REQ_NUMBER-1:0] req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REQ_WIDTH-1:0]  out_request,
  output logic [SEL_W-1:0]      out_select,
  output logic                  out_last
);

  logic [SEL_W-1:0]      ptr;
  logic                  lock_flag;
  logic [SEL_W-1:0]      lock_idx;
  logic [REQ_NUMBER-1:0] grant;
  logic [SEL_W-1:0]      gidx;
  logic                  any_grant;
  logic                  load;
  logic                  accept;
  logic                  acc_last;

  rr_arbiter #(
    .N    (REQ_NUMBER),
    .MODE (ARB_MODE)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .lock_en   (LOCK_PACKETS && lock_flag),
    .lock_idx  (lock_idx),
    .grant     (grant),
    .idx       (gidx),
    .any_grant (any_grant)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign load      = !out_valid || out_ready;
  assign req_ready = (load && !reset) ? grant : '0;
  assign accept    = load && any_grant && !reset;
  assign acc_last  = req_last[gidx];

  // Output stage: capture the accepted beat, clear on drain, hold on stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      out_valid   <= 1'b0;
      out_request <= '0;
      out_select  <= '0;
      out_last    <= 1'b0;
    end else if (load) begin
      out_valid <= accept;
      if (accept) begin
        out_request <= requests[gidx];
        out_select  <= gidx;
        out_last    <= acc_last;
      end
    end
  end

  // Arbitration state: round-robin origin and packet lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      lock_flag <= 1'b0;
      lock_idx  <= '0;
    end else if (accept) begin
      if (!LOCK_PACKETS || acc_last) begin
        ptr <= (gidx == SEL_W'(REQ_NUMBER - 1)) ? '0 : gidx + SEL_W'(1);
      end
      if (LOCK_PACKETS) begin
        lock_flag <= !acc_last;
        lock_idx  <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_request_arbiter_mux.sv
// Bench for request_arbiter_mux: three instances (RR, fixed, RR+lock) share
// stimulus; each is compared every cycle against a rule-level model.
module tb_request_arbiter_mux;
  import request_mux_pkg::*;

  localparam int N = 16;
  localparam int W = 10;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_last;
  logic [W-1:0] requests [N];
  logic         out_ready;

  logic [N-1:0] rdy   [NI];
  logic         ov    [NI];
  logic [W-1:0] oreq  [NI];
  logic [3:0]   osel  [NI];
  logic         olast [NI];

  always #5 clk = ~clk;

  request_arbiter_mux #(.REQ_WIDTH(W), .REQ_NUMBER(N), .ARB_MODE(ARB_RR), .LOCK_PACKETS(1'b0)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last), .requests(requests),
    .req_ready(rdy[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_request(oreq[0]),
    .out_select(osel[0]), .out_last(olast[0]));

  request_arbiter_mux #(.REQ_WIDTH(W), .REQ_NUMBER(N), .ARB_MODE(ARB_FIXED), .LOCK_PACKETS(1'b0)) dut_fx (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last), .requests(requests),
    .req_ready(rdy[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_request(oreq[1]),
    .out_select(osel[1]), .out_last(olast[1]));

  request_arbiter_mux #(.REQ_WIDTH(W), .REQ_NUMBER(N), .ARB_MODE(ARB_RR), .LOCK_PACKETS(1'b1)) dut_lk (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last), .requests(requests),
    .req_ready(rdy[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_request(oreq[2]),
    .out_select(osel[2]), .out_last(olast[2]));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instance configuration and architectural state.
  bit           cfg_rr [NI] = '{1'b1, 1'b0, 1'b1};
  bit           cfg_lk [NI] = '{1'b0, 1'b0, 1'b1};
  bit           m_valid [NI];
  logic [W-1:0] m_req   [NI];
  int           m_sel   [NI];
  bit           m_last  [NI];
  int           m_ptr   [NI];
  bit           m_lock  [NI];
  int           m_lidx  [NI];

  // Which channel wins under the current inputs, or -1 for none.
  function automatic int model_grant(int k);
    if (cfg_lk[k] && m_lock[k]) return req_valid[m_lidx[k]] ? m_lidx[k] : -1;
    for (int o = 0; o < N; o++) begin
      int j;
      j = cfg_rr[k] ? (m_ptr[k] + o) % N : o;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  // One clock: check req_ready before the edge, advance model, check outputs after.
  task automatic cycle();
    int g [NI];
    bit load [NI];
    #1;
    for (int k = 0; k < NI; k++) begin
      g[k]    = model_grant(k);
      load[k] = !m_valid[k] || out_ready;
      check($sformatf("ready[%0d]", k), 32'(rdy[k]),
            (!reset && load[k] && g[k] >= 0) ? (32'd1 << g[k]) : 32'd0);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        m_valid[k] = 1'b0; m_req[k] = '0; m_sel[k] = 0; m_last[k] = 1'b0;
        m_ptr[k] = 0; m_lock[k] = 1'b0; m_lidx[k] = 0;
      end else if (load[k]) begin
        if (g[k] >= 0) begin
          m_valid[k] = 1'b1;
          m_req[k]   = requests[g[k]];
          m_sel[k]   = g[k];
          m_last[k]  = req_last[g[k]];
          if (!cfg_lk[k] || req_last[g[k]]) m_ptr[k] = (g[k] + 1) % N;
          if (cfg_lk[k]) begin
            m_lock[k] = !req_last[g[k]];
            m_lidx[k] = g[k];
          end
        end else begin
          m_valid[k] = 1'b0;
        end
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(m_valid[k]));
      if (m_valid[k]) begin
        check($sformatf("out_request[%0d]", k), 32'(oreq[k]), 32'(m_req[k]));
        check($sformatf("out_select[%0d]", k), 32'(osel[k]), 32'(m_sel[k]));
        check($sformatf("out_last[%0d]", k), 32'(olast[k]), 32'(m_last[k]));
      end
    end
  endtask

  task automatic drive(input bit rst, input logic [N-1:0] v, input logic [N-1:0] l, input bit ordy);
    reset     = rst;
    req_valid = v;
    req_last  = l;
    out_ready = ordy;
    for (int i = 0; i < N; i++) requests[i] = W'($urandom);
    cycle();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_valid[k] = 1'b0; m_req[k] = '0; m_sel[k] = 0; m_last[k] = 1'b0;
      m_ptr[k] = 0; m_lock[k] = 1'b0; m_lidx[k] = 0;
    end

    // Reset state.
    drive(1'b1, '1, '1, 1'b1);
    drive(1'b1, '1, '1, 1'b1);
    for (int k = 0; k < NI; k++) begin
      check("rst out_valid", 32'(ov[k]), 32'd0);
      check("rst out_request", 32'(oreq[k]), 32'd0);
      check("rst out_select", 32'(osel[k]), 32'd0);
      check("rst out_last", 32'(olast[k]), 32'd0);
    end

    // All channels valid, output always ready: RR walks 0..15 then wraps.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '1, '1, 1'b1);
      check("t1 rr select", 32'(osel[0]), 32'(i % N));
      check("t1 rr valid", 32'(ov[0]), 32'd1);
      check("t1 fixed select", 32'(osel[1]), 32'd0);
    end

    // Fixed mode with channels 2 and 4 valid: channel 2 always wins.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 16'h0014, '1, 1'b1);
      check("t2 fixed select", 32'(osel[1]), 32'd2);
    end

    // Backpressure: accept 0x2A5 from channel 5, then stall four cycles.
    reset = 1'b0; req_valid = 16'h0020; req_last = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) requests[i] = W'($urandom);
    requests[5] = 10'h2A5;
    cycle();
    for (int i = 0; i < 4; i++) begin
      req_valid = N'($urandom) | 16'h0020;
      out_ready = 1'b0;
      for (int c = 0; c < N; c++) requests[c] = W'($urandom);
      cycle();
      check("t3 held valid", 32'(ov[0]), 32'd1);
      check("t3 held request", 32'(oreq[0]), 32'h2A5);
      check("t3 held select", 32'(osel[0]), 32'd5);
      check("t3 stalled ready", 32'(rdy[0]), 32'd0);
    end
    drive(1'b0, '0, '1, 1'b1);
    check("t3 drained", 32'(ov[0]), 32'd0);

    // Packet lock: ptr set to 3, then a 3-beat packet on channel 3 with 0 and 7 waiting.
    drive(1'b1, '0, '1, 1'b1);
    drive(1'b0, 16'h0004, '1, 1'b1);
    drive(1'b0, 16'h0089, 16'hFFF7, 1'b1);
    check("t4 beat1", 32'(osel[2]), 32'd3);
    drive(1'b0, 16'h0089, 16'hFFF7, 1'b1);
    check("t4 beat2", 32'(osel[2]), 32'd3);
    check("t4 beat2 locked", 32'(olast[2]), 32'd0);
    drive(1'b0, 16'h0081, 16'hFFF7, 1'b1);
    check("t4 lock stalls others", 32'(ov[2]), 32'd0);
    drive(1'b0, 16'h0089, '1, 1'b1);
    check("t4 beat3", 32'(osel[2]), 32'd3);
    check("t4 beat3 last", 32'(olast[2]), 32'd1);
    drive(1'b0, 16'h0081, '1, 1'b1);
    check("t4 after packet", 32'(osel[2]), 32'd7);
    drive(1'b0, 16'h0081, '1, 1'b1);
    check("t4 wrap to 0", 32'(osel[2]), 32'd0);

    // Reset while holding a beat and locked on channel 9.
    drive(1'b1, '0, '1, 1'b1);
    drive(1'b0, 16'h0200, 16'hFDFF, 1'b1);
    check("t5 locked beat", 32'(osel[2]), 32'd9);
    drive(1'b1, '1, '1, 1'b1);
    for (int k = 0; k < NI; k++) check("t5 reset drops beat", 32'(ov[k]), 32'd0);
    drive(1'b0, '1, '1, 1'b1);
    for (int k = 0; k < NI; k++) check("t5 first after reset", 32'(osel[k]), 32'd0);

    // Wrap: ptr=15, channels 15 and 0 alternate.
    drive(1'b0, 16'h4000, '1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h8001, '1, 1'b1);
      check("t6 rr wrap", 32'(osel[0]), (i % 2 == 0) ? 32'd15 : 32'd0);
      check("t6 lock-rr wrap", 32'(osel[2]), (i % 2 == 0) ? 32'd15 : 32'd0);
    end

    // Randomized traffic with backpressure, packets and occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] v;
      v = ($urandom_range(0, 1) == 0) ? N'($urandom) : (N'($urandom) & N'($urandom) & N'($urandom));
      drive($urandom_range(0, 99) == 0, v, N'($urandom) | N'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
